serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] diff,
  output logic         bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic         ovf,
`endif
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q, diff_q;
  logic [CW-1:0]  cnt_q;
  logic           br_q, bout_q;
  logic           a_bit, b_bit, d_bit, br_nxt, last_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic           ovf_q;
`endif

  // Single full-subtractor cell working on the LSBs of the operand shifters.
  assign a_bit    = a_q[0];
  assign b_bit    = b_q[0];
  assign d_bit    = a_bit ^ b_bit ^ br_q;
  assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign last_bit = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_bit)    state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    dbg_state   = state_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_nxt;
          diff_q <= {d_bit, diff_q[N-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            bout_q <= br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // br_q here is the borrow into the sign bit.
            ovf_q  <= br_q ^ br_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: randomized and directed operations
// checked against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int N = 8;
  localparam int W = N + 2;  // {ovf, bout, diff}

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [N-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf_w;
  logic [1:0]   dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [W-1:0] exp_q[$];

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rstN(rstN),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .bin(bin),
    .res_valid(res_valid), .res_ready(res_ready),
    .diff(diff), .bout(bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_w),
`endif
    .dbg_state(dbg_state)
  );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf_w = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic binv);
    longint ua, ub, r, sa, sb, sr, lo, hi;
    logic [63:0] rr;
    logic bo, ov;
    ua = longint'(av);
    ub = longint'(bv);
    r  = ua - ub - longint'(binv);
    rr = r;
    bo = (ua < ub + longint'(binv));
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    sr = sa - sb - longint'(binv);
    lo = -(longint'(1) << (N - 1));
    hi = (longint'(1) << (N - 1)) - 1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ov = (sr < lo) || (sr > hi);
`else
    ov = 1'b0;
`endif
    return {ov, bo, rr[N-1:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstN && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_unexpected", {ovf_w, bout, diff}, '1);
      end else begin
        chk("result", {ovf_w, bout, diff}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic apply_reset();
    rstN = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // One operation: pa/pb are driven after acceptance, stall = DONE cycles with
  // res_ready low, pulse = offer a bogus start while busy.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic binv,
                        input logic [N-1:0] pa, input logic [N-1:0] pb,
                        input int stall, input bit pulse);
    int t;
    logic [W-1:0] e;
    t = 0;
    while (!start_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!start_ready) chk("start_ready_timeout", start_ready, 1);
    a = av; b = bv; bin = binv;
    start_valid = 1'b1;
    res_ready = (stall == 0);
    @(posedge clk);
    e = model(av, bv, binv);
    exp_q.push_back(e);
    #1;
    start_valid = pulse;
    a = pulse ? 8'h11 : pa;
    b = pb;
    bin = ~binv;
    chk("busy_start_ready", start_ready, 0);
    t = 0;
    while (!res_valid && t < 100) begin @(posedge clk); #1; t++; end
    chk("latency", t, N);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_hold", {ovf_w, bout, diff}, e);
      chk("stall_start_ready", start_ready, 0);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("drop_valid", res_valid, 0);
    chk("ready_back", start_ready, 1);
    res_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_out", {ovf_w, bout, diff}, '0);

    run_op(8'h5A, 8'h23, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 5, 1'b1);

    // Abort after bit 3 has been processed.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_out", {ovf_w, bout, diff}, '0);
    chk("midrst_ready", start_ready, 1);
    @(negedge clk);
    rstN = 1'b1;
    run_op(8'h09, 8'h03, 1'b0, 8'h00, 8'h00, 0, 1'b0);

    run_op(8'h80, 8'h7F, 1'b0, 8'h00, 8'hFF, 0, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    run_op(8'h05, 8'h03, 1'b0, 8'h00, 8'h00, 0, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom),
             N'($urandom), N'($urandom),
             $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
